// File: rtl/ram_arbiter_if.sv
// Signal bundle for the two-requester RAM arbiter and its shared RAM port.
// master: requesters plus RAM (environment side); slave: the arbiter's view.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_grant;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_grant;
  logic              ld_done;
  logic [DATA_W-1:0] ld_rdata;

  logic              ram_read;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;
  logic              busy;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_grant, cpu_done, cpu_rdata,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_grant, ld_done, ld_rdata,
    input  ram_read, ram_write, ram_address, ram_data_in,
    output ram_data_out,
    input  busy
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_grant, cpu_done, cpu_rdata,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_grant, ld_done, ld_rdata,
    output ram_read, ram_write, ram_address, ram_data_in,
    input  ram_data_out,
    output busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port (CPU / program loader) arbiter onto a single synchronous RAM port.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed CPU priority.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              clear,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_grant,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,

  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_grant,
  output logic              ld_done,
  output logic [DATA_W-1:0] ld_rdata,

  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,

  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    COMPLETE
  } state_e;

  state_e            state_q, state_d;
  logic              win_ld_q, win_ld_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              pick_ld;

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic last_ld_q, last_ld_d;

  // Loader wins a tie only when the CPU was served last.
  assign pick_ld = ld_req & (~cpu_req | ~last_ld_q);

  always_comb begin
    last_ld_d = last_ld_q;
    if (state_q == COMPLETE) last_ld_d = win_ld_q;
  end

  always_ff @(posedge clock) begin
    if (clear) last_ld_q <= 1'b1;
    else       last_ld_q <= last_ld_d;
  end
`else
  assign pick_ld = ld_req & ~cpu_req;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      win_ld_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_ld_q    <= win_ld_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    win_ld_d    = win_ld_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    ram_data_in = '0;
    cpu_done    = 1'b0;
    ld_done     = 1'b0;
    cpu_rdata   = cpu_rdata_q;
    ld_rdata    = ld_rdata_q;

    case (state_q)
      IDLE: begin
        if (cpu_req | ld_req) begin
          state_d  = ACCESS;
          win_ld_d = pick_ld;
          we_d     = pick_ld ? ld_we    : cpu_we;
          addr_d   = pick_ld ? ld_addr  : cpu_addr;
          wdata_d  = pick_ld ? ld_wdata : cpu_wdata;
        end
      end
      ACCESS: begin
        ram_read    = ~we_q;
        ram_write   = we_q;
        ram_data_in = wdata_q;
        state_d     = COMPLETE;
      end
      COMPLETE: begin
        state_d  = IDLE;
        cpu_done = ~win_ld_q;
        ld_done  = win_ld_q;
        // RAM data arrives this cycle; forward it so rdata is valid alongside done.
        if (!we_q) begin
          if (win_ld_q) begin
            ld_rdata_d = ram_data_out;
            ld_rdata   = ram_data_out;
          end else begin
            cpu_rdata_d = ram_data_out;
            cpu_rdata   = ram_data_out;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign cpu_grant   = busy & ~win_ld_q;
  assign ld_grant    = busy & win_ld_q;
  assign ram_address = addr_q;

endmodule
